// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- serial UART transmitter
//
// Serialises one DATA_WIDTH-bit word per request onto TX_OUT as
//   start bit (0), data bits LSB first, optional parity bit, stop bit(s) (1).
// Every bit lasts 'prescale' clocks of the shared oversampled clock, the same
// clock and prescale setting used by the companion receiver.
//
// Optional feature macro:
//   UART_TX_TWO_STOP_EN  defined   -> two stop bits; tx_done pulses on the
//                                     final clock of the second stop bit.
//                        undefined -> one stop bit (default build).
//
// Parameters:
//   DATA_WIDTH     data bits per frame (8 in every current pairing)
//
// Ports:
//   clk            in   oversampled bit clock
//   rst            in   synchronous, active-high reset
//   P_DATA         in   word to send, captured on accept only
//   data_valid     in   send request, accepted only while busy=0
//   prescale       in   clocks per bit (0 means 64), captured on accept
//   parity_enable  in   1 inserts a parity bit, captured on accept
//   parity_type    in   0 even / 1 odd, captured on accept
//   TX_OUT         out  serial line, idle high, registered
//   busy           out  high from the accept edge until the frame ends
//   tx_done        out  one-clock pulse on the last clock of the frame
//
// Handshake: a request is accepted on any posedge where data_valid=1 and the
// transmitter is idle (busy=0). There is no queue: requests seen while busy
// are dropped, and a request held high starts the next frame on the first
// idle edge, leaving exactly one idle-high clock between frames.
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  data_valid,
   input  logic [5:0]            prescale,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ---------------------------------------------------------------------------
   // State and frame-context registers
   // ---------------------------------------------------------------------------
   state_t                state_q,   state_d;
   logic [5:0]            cnt_q,     cnt_d;      // clock-within-bit counter
   logic [BW-1:0]         bit_q,     bit_d;      // data bit index
   logic [DATA_WIDTH-1:0] data_q,    data_d;     // latched word
   logic [5:0]            ps_q,      ps_d;       // latched prescale
   logic                  par_en_q,  par_en_d;   // latched parity enable
   logic                  par_bit_q, par_bit_d;  // precomputed parity bit
   logic                  tx_q,      tx_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;
   logic                  cnt_wrap;
   logic                  stop_last_d;           // current stop bit is the final one

`ifdef UART_TX_TWO_STOP_EN
   logic                  stop2_q,   stop2_d;    // 1 while in the second stop bit
`endif

   // The counter wraps after ps_q clocks; ps_q=0 gives 6'd63 here, so a
   // zero prescale naturally yields 64 clocks per bit.
   assign cnt_wrap = (cnt_q == (ps_q - 6'd1));

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      data_d    = data_q;
      ps_d      = ps_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`ifdef UART_TX_TWO_STOP_EN
      stop2_d   = stop2_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (data_valid) begin
               state_d   = S_START;
               cnt_d     = 6'd0;
               bit_d     = '0;
               data_d    = P_DATA;
               ps_d      = prescale;
               par_en_d  = parity_enable;
               // Even parity is the XOR of the data; odd is its inverse.
               par_bit_d = (^P_DATA) ^ parity_type;
`ifdef UART_TX_TWO_STOP_EN
               stop2_d   = 1'b0;
`endif
            end
         end

         S_START: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_wrap) begin
               cnt_d   = 6'd0;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_wrap) begin
               cnt_d = 6'd0;
               if (bit_q == LAST_BIT) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end

         S_PARITY: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_wrap) begin
               cnt_d   = 6'd0;
               state_d = S_STOP;
            end
         end

         S_STOP: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_wrap) begin
               cnt_d = 6'd0;
`ifdef UART_TX_TWO_STOP_EN
               if (!stop2_q) begin
                  stop2_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
`else
               state_d = S_IDLE;
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
            bit_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode from the *next* state so every output is a flop and the
   // line changes on the same edge as the state (zero accept latency).
   // ---------------------------------------------------------------------------
`ifdef UART_TX_TWO_STOP_EN
   assign stop_last_d = stop2_d;
`else
   assign stop_last_d = 1'b1;
`endif

   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_d];
         S_PARITY: tx_d = par_bit_d;
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      // High during the cycle that holds the final clock of the final stop bit.
      done_d = (state_d == S_STOP) && (cnt_d == (ps_d - 6'd1)) && stop_last_d;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         bit_q     <= '0;
         data_q    <= '0;
         ps_q      <= 6'd0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop2_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         ps_q      <= ps_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef UART_TX_TWO_STOP_EN
         stop2_q   <= stop2_d;
`endif
      end
   end

   assign TX_OUT  = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx
//
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, well away from the active edge. Frames are described as a vector of
// the bits sent before the stop bit(s), bit 0 first on the line.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif

   // ---------------------------------------------------------------------------
   // Clock / reset and DUT
   // ---------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic [5:0] prescale;
   logic       parity_enable;
   logic       parity_type;
   logic       TX_OUT;
   logic       busy;
   logic       tx_done;

   always #5 clk = ~clk;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .P_DATA        (P_DATA),
      .data_valid    (data_valid),
      .prescale      (prescale),
      .parity_enable (parity_enable),
      .parity_type   (parity_type),
      .TX_OUT        (TX_OUT),
      .busy          (busy),
      .tx_done       (tx_done)
   );

   int n_total = 0;
   int n_pass  = 0;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Presents a request for exactly one accept edge.
   task automatic start_frame(input logic [7:0] d, input logic [5:0] ps,
                              input logic pe, input logic pt);
      P_DATA        = d;
      prescale      = ps;
      parity_enable = pe;
      parity_type   = pt;
      data_valid    = 1'b1;
      tick();
      data_valid    = 1'b0;
   endtask

   // Called in the first clock after the accept edge. Checks every bit for its
   // whole duration, busy length, a single tx_done on the last clock, and the
   // idle-high gap clock that follows. 'mode' injects mid-frame input activity:
   //   1: change P_DATA / prescale / parity while data_valid stays high
   //   2: drop data_valid, then pulse it once mid-frame
   task automatic check_frame(input logic [9:0] frame, input int nbits,
                              input int pclk, input int mode, input string tag);
      int   busy_n;
      int   done_n;
      logic seen;
      logic expb;
      logic done_last;
      busy_n    = 0;
      done_n    = 0;
      done_last = 1'b0;
      for (int b = 0; b < nbits + NSTOP; b++) begin
         expb = (b < nbits) ? frame[b] : 1'b1;
         seen = expb;
         for (int c = 0; c < pclk; c++) begin
            if (mode == 1 && b == 3 && c == 0) begin
               P_DATA        = 8'hAA;
               prescale      = 6'd20;
               parity_enable = 1'b1;
            end
            if (mode == 1 && b == 6 && c == 0) begin
               prescale      = 6'd8;
               parity_enable = 1'b0;
            end
            if (mode == 2 && b == 0 && c == 0) data_valid = 1'b0;
            if (mode == 2 && b == 4 && c == 0) data_valid = 1'b1;
            if (mode == 2 && b == 4 && c == 1) data_valid = 1'b0;
            if (TX_OUT !== expb) seen = TX_OUT;
            if (busy === 1'b1) busy_n++;
            if (tx_done === 1'b1) done_n++;
            if (b == nbits + NSTOP - 1 && c == pclk - 1) done_last = tx_done;
            tick();
         end
         check($sformatf("%s_bit%0d", tag, b), {31'd0, seen}, {31'd0, expb});
      end
      check({tag, "_busy_len"},  busy_n, (nbits + NSTOP) * pclk);
      check({tag, "_done_last"}, {31'd0, done_last}, 32'd1);
      check({tag, "_done_cnt"},  done_n, 32'd1);
      check({tag, "_gap_tx"},    {31'd0, TX_OUT},  32'd1);
      check({tag, "_gap_busy"},  {31'd0, busy},    32'd0);
      check({tag, "_gap_done"},  {31'd0, tx_done}, 32'd0);
   endtask

   // Loopback receiver: mid-bit sampling of TX_OUT, even/odd parity check and
   // stop-bit check, with bounded waits.
   task automatic rx_byte(input int pclk, input logic pe, input logic pt,
                          output logic [7:0] d, output logic perr,
                          output logic serr, output logic tmo);
      int   n;
      logic p;
      n    = 0;
      d    = 8'h00;
      perr = 1'b0;
      while (TX_OUT !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      tmo = (n >= 200);
      repeat (pclk / 2) tick();
      serr = (TX_OUT !== 1'b0);
      for (int i = 0; i < 8; i++) begin
         repeat (pclk) tick();
         d[i] = TX_OUT;
      end
      if (pe) begin
         repeat (pclk) tick();
         p    = TX_OUT;
         perr = (p !== ((^d) ^ pt));
      end
      repeat (pclk) tick();
      serr = serr | (TX_OUT !== 1'b1);
      n = 0;
      while (busy !== 1'b0 && n < 4 * pclk) begin
         tick();
         n++;
      end
      tmo = tmo | (n >= 4 * pclk);
      tick();
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   logic [7:0] rx_d;
   logic       rx_perr;
   logic       rx_serr;
   logic       rx_tmo;
   logic [7:0] lb_bytes [3];

   initial begin
      rst           = 1'b1;
      P_DATA        = 8'h00;
      data_valid    = 1'b0;
      prescale      = 6'd16;
      parity_enable = 1'b0;
      parity_type   = 1'b0;
      repeat (3) tick();
      check("rst_tx",   {31'd0, TX_OUT},  32'd1);
      check("rst_busy", {31'd0, busy},    32'd0);
      check("rst_done", {31'd0, tx_done}, 32'd0);
      rst = 1'b0;
      tick();
      check("idle_tx", {31'd0, TX_OUT}, 32'd1);

      // 0xB4 even parity: 0, 0,0,1,0,1,1,0,1, 0, stop
      start_frame(8'hB4, 6'd32, 1'b1, 1'b0);
      check_frame(10'b0_10110100_0, 10, 32, 0, "even");
      tick();

      // 0xB4 odd parity: parity bit becomes 1
      start_frame(8'hB4, 6'd32, 1'b1, 1'b1);
      check_frame(10'b1_10110100_0, 10, 32, 0, "odd");
      tick();

      // 0x0F no parity, 8 clocks per bit: 0, 1,1,1,1,0,0,0,0, stop
      start_frame(8'h0F, 6'd8, 1'b0, 1'b0);
      check_frame(10'b0_00001111_0, 9, 8, 0, "nopar");
      tick();

      // prescale=0 means 64 clocks per bit
      start_frame(8'h01, 6'd0, 1'b0, 1'b0);
      check_frame(10'b0_00000001_0, 9, 64, 0, "ps0");
      tick();

      // Back-to-back: request held high, inputs changed mid-frame
      P_DATA        = 8'h55;
      prescale      = 6'd8;
      parity_enable = 1'b0;
      parity_type   = 1'b0;
      data_valid    = 1'b1;
      tick();
      check_frame(10'b0_01010101_0, 9, 8, 1, "b2b_a");
      tick();  // request still high: accepted on the first idle edge
      check_frame(10'b0_10101010_0, 9, 8, 2, "b2b_b");
      tick();
      check("b2b_noqueue_busy", {31'd0, busy},   32'd0);
      check("b2b_noqueue_tx",   {31'd0, TX_OUT}, 32'd1);

      // Reset during data bit 3 of 0xC3 (that bit is 0)
      start_frame(8'hC3, 6'd8, 1'b0, 1'b0);
      repeat (4 * 8 + 2) tick();
      check("midrst_pre_tx",   {31'd0, TX_OUT}, 32'd0);
      check("midrst_pre_busy", {31'd0, busy},   32'd1);
      rst = 1'b1;
      tick();
      check("midrst_tx",   {31'd0, TX_OUT},  32'd1);
      check("midrst_busy", {31'd0, busy},    32'd0);
      check("midrst_done", {31'd0, tx_done}, 32'd0);
      rst = 1'b0;
      tick();
      start_frame(8'h3C, 6'd8, 1'b0, 1'b0);
      check_frame(10'b0_00111100_0, 9, 8, 0, "postrst");
      tick();

      // Loopback through the bench receiver, prescale 16, even parity
      lb_bytes[0] = 8'h00;
      lb_bytes[1] = 8'hFF;
      lb_bytes[2] = 8'hA5;
      for (int k = 0; k < 3; k++) begin
         start_frame(lb_bytes[k], 6'd16, 1'b1, 1'b0);
         rx_byte(16, 1'b1, 1'b0, rx_d, rx_perr, rx_serr, rx_tmo);
         check($sformatf("lb%0d_data", k), {24'd0, rx_d}, {24'd0, lb_bytes[k]});
         check($sformatf("lb%0d_perr", k), {31'd0, rx_perr}, 32'd0);
         check($sformatf("lb%0d_serr", k), {31'd0, rx_serr}, 32'd0);
         check($sformatf("lb%0d_tmo",  k), {31'd0, rx_tmo},  32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter; the transmit-side counterpart of the team's UART_RX block.
- Accepts a byte with a valid strobe and serialises it onto TX_OUT as: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Runs on the same oversampled clock as the receiver; each bit lasts prescale clocks, so TX and RX share one clock tree and one prescale setting.
- Sits between the system-side data source and the line; its output loops back directly into the RX for self-test.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; the bench and RX pairing use only 8.

Ports:
clk  input  1  system clock (oversampled bit clock).
rst  input  1  synchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled only on accept.
data_valid  input  1  request to send P_DATA; accepted only while busy=0.
prescale  input  6  clocks per bit (8/16/32 nominal); sampled on accept.
parity_enable  input  1  1 = insert parity bit; sampled on accept.
parity_type  input  1  0 = even, 1 = odd; sampled on accept.
TX_OUT  output  1  serial line, idle high; registered.
busy  output  1  high from the accept edge until the frame ends; registered.
tx_done  output  1  one-clock pulse on the final clock of the last stop bit.

Behaviour:
- Reset (sync, checked every posedge): TX_OUT=1, busy=0, tx_done=0, state=IDLE, bit and clock counters=0. Reset mid-frame abandons the frame; the line returns high on the same edge.
- FSM states: IDLE -> START -> DATA -> (PARITY if latched parity_enable) -> STOP -> IDLE.
- IDLE:
  - TX_OUT=1, busy=0.
  - data_valid=1 at a posedge latches P_DATA, prescale, parity_enable and parity_type, computes the parity bit, and enters START.
  - On that same edge TX_OUT goes 0 and busy goes 1. Zero-cycle latency from accept edge to start-bit edge.
- Bit timing:
  - A 6-bit clock counter runs from 0 to latched_prescale-1 and then wraps.
  - The state or bit advances on the wrap.
  - prescale=0 behaves as 64 clocks per bit, through natural 6-bit wraparound.
- DATA: drives the latched data[0] first through data[7], each for prescale clocks, indexed by a 3-bit bit counter. It leaves DATA on the wrap of bit 7.
- PARITY:
  - Even: the parity bit is XOR of the 8 data bits.
  - Odd: the parity bit is its inverse.
  - Computed from the latched byte, not the live input.
- STOP: TX_OUT=1 for prescale clocks. On the last clock of STOP, tx_done=1 for that single cycle. On the following edge the FSM is in IDLE and busy=0.
- Frame length in clocks: (10 + parity_enable) × prescale, measured from the accept edge to busy falling.
- Back-to-back frames:
  - data_valid held high continuously starts the next frame on the first edge in IDLE. Minimum gap between frames is 1 clock of idle-high.
  - data_valid while busy=1 is ignored and not queued. P_DATA, prescale and parity input changes mid-frame have no effect.
- Outputs are glitch-free: TX_OUT, busy and tx_done all come straight from flops.

Optional Feature:
UART_TX_TWO_STOP_EN:
- Defined: STOP lasts 2 × prescale clocks (two stop bits), tx_done pulses on the final clock of the second stop bit, and frame length is (11 + parity_enable) × prescale.
- Undefined: one stop bit, exactly as in Behaviour.

Test Plan:
1. Even parity: prescale=32, parity_enable=1, parity_type=0, P_DATA=0xB4, data_valid pulsed 1 clock.
   - TX_OUT bit sequence is 0, 0,0,1,0,1,1,0,1, 0, 1, each bit exactly 32 clocks.
   - busy is high for 352 clocks; tx_done pulses once.
2. Odd parity: parity_type=1, P_DATA=0xB4 -> parity bit = 1; all other bits as in scenario 1.
3. Parity disabled: parity_enable=0, prescale=8, P_DATA=0x0F -> TX_OUT is 0, 1,1,1,1,0,0,0,0, 1. Frame is 80 clocks with no parity slot.
4. Back-to-back with ignore: data_valid held high with P_DATA=0x55; P_DATA changed to 0xAA mid-frame.
   - First frame carries 0x55; the next frame starts exactly 1 idle clock after busy falls and carries 0xAA.
   - A data_valid pulse mid-frame causes no corruption.
5. Reset mid-frame: rst=1 during DATA bit 3 -> TX_OUT=1, busy=0, tx_done=0 at the next edge. A new accept after rst=0 sends a clean frame.
6. Loopback: TX_OUT wired to the UART_RX RX_IN, prescale=16, even parity, bytes 0x00, 0xFF, 0xA5.
   - RX data_valid fires with P_DATA equal to each byte.
   - parity_error=0 and stop_error=0 throughout.
